// File: rtl/gf233_pkg.sv
// Shared constants and controller state encoding for the GF(2^233) inverter.
package gf233_pkg;

  localparam int M         = 233;
  localparam int W         = 256;
  localparam int TAP       = 74;
  localparam int SQ_COUNT  = 232;
  localparam int MUL_COUNT = 231;

  localparam logic [M-1:0] FIELD_ONE = 233'h1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SQR,
    ST_SQR_W,
    ST_MUL,
    ST_MUL_W,
    ST_DONE
  } state_e;

endpackage

// File: rtl/ks256.sv
// 256x256 carry-less Karatsuba multiplier with reduction modulo x^233 + x^74 + 1.
// The full 511-bit product and the 233-bit reduced field element are both exposed.
module ks256
  import gf233_pkg::*;
(
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-2:0] prod_o,
  output logic [M-1:0]   red_o
);

  // 128x128 carry-less product (schoolbook), used for the three Karatsuba terms
  function automatic logic [254:0] clmul128(input logic [127:0] x, input logic [127:0] y);
    logic [254:0] acc;
    acc = '0;
    for (int i = 0; i < 128; i++) begin
      if (y[i]) acc = acc ^ ({127'b0, x} << i);
    end
    return acc;
  endfunction

  // Fold every bit at or above x^233 down using x^233 = x^74 + 1, top bit first
  function automatic logic [M-1:0] reduce(input logic [2*W-2:0] p_in);
    logic [2*W-2:0] p;
    p = p_in;
    for (int i = 2*W-2; i >= M; i--) begin
      if (p[i]) begin
        p[i]           = 1'b0;
        p[i - M + TAP] = ~p[i - M + TAP];
        p[i - M]       = ~p[i - M];
      end
    end
    return p[M-1:0];
  endfunction

  logic [254:0] lo, hi, mid;

  // One Karatsuba level: lo*hi cross term recovered from (al^ah)(bl^bh)
  always_comb begin
    lo     = clmul128(a_i[127:0], b_i[127:0]);
    hi     = clmul128(a_i[255:128], b_i[255:128]);
    mid    = clmul128(a_i[127:0] ^ a_i[255:128], b_i[127:0] ^ b_i[255:128]) ^ lo ^ hi;
    prod_o = ({256'b0, hi} << 256) ^ ({256'b0, mid} << 128) ^ {256'b0, lo};
    red_o  = reduce(prod_o);
  end

endmodule

// File: rtl/gf233_inverter.sv
// Constant-time GF(2^233) inverter: a^-1 = a^(2^233 - 2) by left-to-right
// square-and-multiply, driving one shared ks256 multiplier.
module gf233_inverter #(
  parameter int M       = 233,
  parameter int W       = 256,
  parameter int MUL_REG = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_inv,
  output logic         out_zero
);
  import gf233_pkg::*;

  localparam logic [7:0] CNT_INIT = 8'(MUL_COUNT);

  if (M != 233 || W != 256 || SQ_COUNT != MUL_COUNT + 1) begin : g_bad_cfg
    $error("gf233_inverter supports only M=233, W=256");
  end

  state_e         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [M-1:0]   r_q, r_d;
  logic [M-1:0]   a_q, a_d;
  logic           zero_q, zero_d;

  logic [W-1:0]   op_a, op_b;
  logic [M-1:0]   mul_red;
  logic [M-1:0]   mul_res;
  logic [2*W-2:0] mul_prod_unused;

  // Operand mux: squaring uses r twice, multiply pairs r with the saved operand
  always_comb begin
    op_a = {{(W-M){1'b0}}, r_q};
    op_b = {{(W-M){1'b0}}, r_q};
    if (state_q == ST_MUL || state_q == ST_MUL_W) op_b = {{(W-M){1'b0}}, a_q};
  end

  ks256 u_mul (
    .a_i    (op_a),
    .b_i    (op_b),
    .prod_o (mul_prod_unused),
    .red_o  (mul_red)
  );

  if (MUL_REG != 0) begin : g_mulreg
    logic [M-1:0] res_q;
    // Pipeline register on the multiplier output; consumed in the _W substates
    always_ff @(posedge clk) res_q <= mul_red;
    assign mul_res = res_q;
  end else begin : g_mulcomb
    assign mul_res = mul_red;
  end

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    a_d       = a_q;
    zero_d    = zero_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_inv   = '0;
    out_zero  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          r_d     = in_a;
          cnt_d   = CNT_INIT;
          zero_d  = (in_a == '0);
          state_d = ST_SQR;
        end
      end
      ST_SQR: begin
        if (MUL_REG != 0) begin
          state_d = ST_SQR_W;
        end else begin
          r_d     = mul_res;
          state_d = (cnt_q != 8'd0) ? ST_MUL : ST_DONE;
        end
      end
      ST_SQR_W: begin
        r_d     = mul_res;
        state_d = (cnt_q != 8'd0) ? ST_MUL : ST_DONE;
      end
      ST_MUL: begin
        if (MUL_REG != 0) begin
          state_d = ST_MUL_W;
        end else begin
          r_d     = mul_res;
          cnt_d   = cnt_q - 8'd1;
          state_d = ST_SQR;
        end
      end
      ST_MUL_W: begin
        r_d     = mul_res;
        cnt_d   = cnt_q - 8'd1;
        state_d = ST_SQR;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        out_inv   = r_q;
        out_zero  = zero_q;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      a_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      a_q     <= a_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_gf233_inverter.sv
// Directed bench for gf233_inverter: both MUL_REG variants run side by side on shared inputs.
module tb_gf233_inverter;
  import gf233_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [232:0] in_a = '0;
  logic         out_ready = 1'b0;

  logic         ready0, valid0, zero0;
  logic [232:0] inv0;
  logic         ready1, valid1, zero1;
  logic [232:0] inv1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gf233_inverter #(.M(233), .W(256), .MUL_REG(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready0), .in_a(in_a),
    .out_valid(valid0), .out_ready(out_ready), .out_inv(inv0), .out_zero(zero0)
  );

  gf233_inverter #(.M(233), .W(256), .MUL_REG(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready1), .in_a(in_a),
    .out_valid(valid1), .out_ready(out_ready), .out_inv(inv1), .out_zero(zero1)
  );

  task automatic chk(input string tag, input logic [232:0] got, input logic [232:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference field multiply: shift-and-add with on-the-fly reduction
  function automatic logic [232:0] fmul(input logic [232:0] a, input logic [232:0] b);
    logic [232:0] acc, sh;
    logic         carry;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 233; i++) begin
      if (b[i]) acc = acc ^ sh;
      carry = sh[232];
      sh    = sh << 1;
      if (carry) sh = sh ^ ((233'h1 << TAP) | 233'h1);
    end
    return acc;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, " in_ready0"},  233'(ready0), 233'(1));
    chk({tag, " out_valid0"}, 233'(valid0), 233'(0));
    chk({tag, " out_inv0"},   inv0, '0);
    chk({tag, " out_zero0"},  233'(zero0), 233'(0));
    chk({tag, " in_ready1"},  233'(ready1), 233'(1));
    chk({tag, " out_valid1"}, 233'(valid1), 233'(0));
    chk({tag, " out_inv1"},   inv1, '0);
    chk({tag, " out_zero1"},  233'(zero1), 233'(0));
  endtask

  // Accept one operand, wait for both results, check latency, optionally stall, then handshake
  task automatic run_op(input string tag, input logic [232:0] a, input bit hold,
                        output logic [232:0] r0, output logic [232:0] r1,
                        output logic z0, output logic z1);
    int lat0, lat1;
    logic [232:0] h0, h1;
    @(negedge clk);
    chk({tag, " ready0 before accept"}, 233'(ready0), 233'(1));
    chk({tag, " ready1 before accept"}, 233'(ready1), 233'(1));
    in_a      = a;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat0 = -1;
    lat1 = -1;
    for (int k = 1; k <= 1200; k++) begin
      @(negedge clk);
      if (valid0 && lat0 < 0) lat0 = k;
      if (valid1 && lat1 < 0) lat1 = k;
      if (lat0 >= 0 && lat1 >= 0) break;
      @(posedge clk);
    end
    chk({tag, " latency MUL_REG=0"}, 233'(lat0), 233'(464));
    chk({tag, " latency MUL_REG=1"}, 233'(lat1), 233'(927));
    chk({tag, " in_ready0 in DONE"}, 233'(ready0), 233'(0));
    chk({tag, " in_ready1 in DONE"}, 233'(ready1), 233'(0));
    r0 = inv0; r1 = inv1; z0 = zero0; z1 = zero1;
    if (hold) begin
      h0 = inv0;
      h1 = inv1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        chk({tag, " stall valid0"}, 233'(valid0), 233'(1));
        chk({tag, " stall valid1"}, 233'(valid1), 233'(1));
        chk({tag, " stall inv0"}, inv0, h0);
        chk({tag, " stall inv1"}, inv1, h1);
        chk({tag, " stall ready0"}, 233'(ready0), 233'(0));
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " ready0 after handshake"}, 233'(ready0), 233'(1));
    chk({tag, " valid0 after handshake"}, 233'(valid0), 233'(0));
    chk({tag, " ready1 after handshake"}, 233'(ready1), 233'(1));
    chk({tag, " valid1 after handshake"}, 233'(valid1), 233'(0));
  endtask

  initial begin
    logic [232:0] r0, r1, a, e2;
    logic         z0, z1;
    bit           seen;

    e2 = (233'h1 << 232) | (233'h1 << 73);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    run_op("a=1", 233'h1, 1'b0, r0, r1, z0, z1);
    chk("a=1 inv0", r0, FIELD_ONE);
    chk("a=1 inv1", r1, FIELD_ONE);
    chk("a=1 zero0", 233'(z0), 233'(0));
    chk("a=1 zero1", 233'(z1), 233'(0));

    run_op("a=x", 233'h2, 1'b0, r0, r1, z0, z1);
    chk("a=x inv0", r0, e2);
    chk("a=x inv1", r1, e2);
    chk("a=x product0", fmul(233'h2, r0), FIELD_ONE);

    run_op("a=0", 233'h0, 1'b0, r0, r1, z0, z1);
    chk("a=0 inv0", r0, '0);
    chk("a=0 inv1", r1, '0);
    chk("a=0 zero0", 233'(z0), 233'(1));
    chk("a=0 zero1", 233'(z1), 233'(1));

    a = '1;
    run_op("a=ones", a, 1'b0, r0, r1, z0, z1);
    chk("a=ones product0", fmul(a, r0), FIELD_ONE);
    chk("a=ones product1", fmul(a, r1), FIELD_ONE);
    chk("a=ones zero0", 233'(z0), 233'(0));

    for (int t = 0; t < 8; t++) begin
      a = '0;
      for (int w = 0; w < 8; w++) a = {a[200:0], 32'($urandom())};
      if (a == '0) a = 233'h1;
      run_op("random", a, 1'b0, r0, r1, z0, z1);
      chk("random product0", fmul(a, r0), FIELD_ONE);
      chk("random product1", fmul(a, r1), FIELD_ONE);
    end

    a = 233'h3;
    run_op("stall a=x+1", a, 1'b1, r0, r1, z0, z1);
    chk("stall product0", fmul(a, r0), FIELD_ONE);
    chk("stall product1", fmul(a, r1), FIELD_ONE);

    // Abort an operation around cycle 100 with a one-cycle reset pulse
    @(negedge clk);
    in_a     = 233'h5;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("abort");
    seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (valid0 || valid1) seen = 1'b1;
    end
    chk("abort no result emitted", 233'(seen), 233'(0));

    run_op("after abort a=x", 233'h2, 1'b0, r0, r1, z0, z1);
    chk("after abort inv0", r0, e2);
    chk("after abort inv1", r1, e2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gf233_inverter.md
Name: gf233_inverter

Overview:
Sequential multiplicative inverter for GF(2^233), reduction polynomial x^233 + x^74 + 1. It sits directly downstream of the existing 256-bit Karatsuba multiplier and drives that multiplier iteratively through its 233-bit reduced output port. It computes a^-1 = a^(2^233 - 2) by left-to-right square-and-multiply. It serves as the field-inversion stage for affine-coordinate conversion in the point-arithmetic datapath.

Parameters:
M, 233, field degree; only 233 is supported.
W, 256, multiplier operand width; operands are zero-extended from M to W.
MUL_REG, 0, 0 = use the multiplier result in the same cycle; 1 = register the multiplier result, so every field operation takes 2 cycles.

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operand a is valid
in_ready  output  1  block accepts an operand; high only in IDLE
in_a  input  233  operand a, canonical field element
out_valid  output  1  result is valid; held until accepted
out_ready  input  1  downstream accepts the result
out_inv  output  233  a^-1; 0 when a = 0
out_zero  output  1  flags that a = 0 (inverse undefined); qualified by out_valid

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_inv = 0, out_zero = 0, cnt = 0, r = 0, a_reg = 0.
- rst asserted at any point, including mid-operation, aborts the operation on the next edge and returns all outputs to reset values. No partial result is emitted.
- States: IDLE, SQR, MUL, DONE. When MUL_REG = 1, SQR and MUL each also have a one-cycle wait substate, SQR_W and MUL_W.
- IDLE:
  - in_ready = 1.
  - On in_valid: a_reg <= in_a, r <= in_a, cnt <= 231, zero_flag <= (in_a == 0), go to SQR.
- SQR:
  - Multiplier operands are {23'b0, r} and {23'b0, r}.
  - r <= reduced result.
  - If cnt != 0, go to MUL; otherwise go to DONE.
- MUL:
  - Multiplier operands are {23'b0, r} and {23'b0, a_reg}.
  - r <= reduced result, cnt <= cnt - 1, go to SQR.
- Invariant: after k SQR/MUL pairs, r = a^(2^(k+1) - 1). After 231 pairs plus the final SQR, r = a^(2^233 - 2).
- Operation count: 232 SQR plus 231 MUL = 463 operations.
- Latency, from the accept edge to the first cycle with out_valid = 1:
  - 464 cycles when MUL_REG = 0.
  - 927 cycles when MUL_REG = 1.
- DONE:
  - out_valid = 1, out_inv = r, out_zero = zero_flag.
  - Outputs stay stable while out_ready = 0.
  - On out_valid && out_ready, go to IDLE.
  - in_ready stays 0 in DONE, so a new operand cannot be accepted in the same cycle the result handshake completes. The earliest next accept is one cycle later.
- Zero input: the algorithm naturally yields r = 0. out_inv must equal 0 and out_zero = 1. Full latency is still spent, so timing is constant and independent of the data.
- Timing is data-independent for every input, as required for side-channel resistance.
- The multiplier's 511-bit product port is unused. Only its 233-bit reduced output is consumed.
- in_a is assumed canonical. Upper multiplier operand bits [255:233] are always driven to 0.
- cnt width is 8 bits; it counts down from 231 and never wraps.

Decomposition:
- Shared package gf233_pkg holds:
  - constants M = 233, W = 256, TAP = 74, SQ_COUNT = 232, MUL_COUNT = 231, FIELD_ONE = 233'h1;
  - the state enum typedef.
- Sub-module: one instance of the existing ks256 multiplier, used via its result output.
- No further sub-module is needed. The controller and operand mux live in gf233_inverter.

Test Plan:
- a = 1 -> out_inv = 1, out_zero = 0, out_valid first high 464 cycles after accept (MUL_REG = 0).
- a = 2 (x) -> out_inv has only bits 232 and 73 set (x^232 + x^73); the ks256 result of in_a and out_inv equals 1.
- a = 0 -> out_inv = 0, out_zero = 1, latency still 464 cycles.
- 200 random nonzero a, including all-ones 233'h1FF..F -> the ks256 result of a and out_inv equals 1 for every case. Repeat with MUL_REG = 1 and check latency = 927 cycles.
- Hold out_ready = 0 for 10 cycles in DONE -> out_valid and out_inv stable, in_ready = 0; raise out_ready -> IDLE next cycle, in_ready = 1.
- Assert rst for 1 cycle at cycle 100 of an operation -> out_valid stays 0 and outputs return to reset values. A new operation with a = 2 afterwards completes correctly with the full latency.
